// File: rtl/dwt97_pkg.sv
// Shared types for the 2D 9/7 DWT pass sequencer.
//   state_t    : sequencer FSM states
//   pass_dir_t : pass direction (row / column)
//   side_width : width of a tile-side quantity for a given maximum side size
package dwt97_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_FEED,
    S_DRAIN,
    S_NEXT,
    S_DONE
  } state_t;

  typedef enum logic {
    DIR_ROW = 1'b0,
    DIR_COL = 1'b1
  } pass_dir_t;

  // One extra bit so the maximum side size itself is representable.
  function automatic int unsigned side_width(input int unsigned max_side);
    return $clog2(max_side) + 1;
  endfunction

endpackage

// File: rtl/dwt97_frame_counter.sv
// Pair/line position tracker used to frame one pass of the pair stream.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   clear             : restart at pair 0 of line 0
//   advance           : one pair was transferred
//   pairs, lines      : geometry of the current pass
//   sof_c             : current position is pair 0 of line 0
//   eol_c             : current position is the last pair of a line
//   last_line_c       : current position is on the last line
module dwt97_frame_counter
  import dwt97_pkg::*;
#(
  parameter int unsigned SideW = side_width(512)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear,
  input  logic             advance,
  input  logic [SideW-1:0] pairs,
  input  logic [SideW-1:0] lines,
  output logic             sof_c,
  output logic             eol_c,
  output logic             last_line_c
);

  logic [SideW-1:0] pair_cnt;
  logic [SideW-1:0] line_cnt;

  assign sof_c       = (pair_cnt == '0) && (line_cnt == '0);
  assign eol_c       = (pair_cnt == pairs - SideW'(1));
  assign last_line_c = (line_cnt == lines - SideW'(1));

  // Pair counter wraps at end of line; line counter steps on each eol.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      pair_cnt <= '0;
      line_cnt <= '0;
    end else if (advance) begin
      if (eol_c) begin
        pair_cnt <= '0;
        line_cnt <= line_cnt + SideW'(1);
      end else begin
        pair_cnt <= pair_cnt + SideW'(1);
      end
    end
  end

endmodule

// File: rtl/dwt97_pass_sequencer.sv
// Multi-level 2D 9/7 DWT pass sequencer around one shared 1D DWT core.
// Issues a row and a column pass per level, frames the pair stream with
// sof/eol and waits for the core output to drain before the next pass.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   cfg_width/height/levels_i     : tile configuration, sampled on start
//   start_i, busy_o, done_o, error_o : job control and status
//   cmd_*                         : pass descriptor to the address generator
//   s_*                           : unframed pair stream in
//   m_*                           : framed pair stream to the core
//   r_valid/ready/eol_i           : core output handshake monitor
module dwt97_pass_sequencer
  import dwt97_pkg::*;
#(
  parameter  int unsigned DataWidth       = 16,
  parameter  int unsigned MaximumSideSize = 512,
  parameter  int unsigned MaxLevels       = 5,
  localparam int unsigned SideW           = side_width(MaximumSideSize),
  localparam int unsigned LvlW            = $clog2(MaxLevels + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [SideW-1:0]       cfg_width_i,
  input  logic [SideW-1:0]       cfg_height_i,
  input  logic [LvlW-1:0]        cfg_levels_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o,
  output logic                   cmd_valid_o,
  input  logic                   cmd_ready_i,
  output logic                   cmd_dir_o,
  output logic [LvlW-1:0]        cmd_level_o,
  output logic [SideW-1:0]       cmd_lines_o,
  output logic [SideW-1:0]       cmd_pairs_o,
  input  logic                   s_valid_i,
  output logic                   s_ready_o,
  input  logic [2*DataWidth-1:0] s_data_i,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o,
  input  logic                   r_valid_i,
  input  logic                   r_ready_i,
  input  logic                   r_eol_i
);

  state_t           state;
  pass_dir_t        dir_q;
  logic [SideW-1:0] w_q;
  logic [SideW-1:0] h_q;
  logic [LvlW-1:0]  levels_q;
  logic [LvlW-1:0]  lvl_q;
  logic [LvlW-1:0]  lvl_inc;
  logic [SideW-1:0] drain_cnt;
  logic [SideW-1:0] drain_cnt_nxt;

  logic feed;
  logic advance;
  logic cmd_fire;
  logic drain_inc;
  logic pass_end;
  logic sof_c;
  logic eol_c;
  logic last_line_c;

  // Configuration acceptance: level range, divisibility, minimum pass size.
  function automatic logic cfg_valid(input logic [SideW-1:0] w,
                                     input logic [SideW-1:0] h,
                                     input logic [LvlW-1:0]  l);
    logic [SideW-1:0] mask;
    logic [LvlW-1:0]  deepest;
    mask    = (SideW'(1) << l) - SideW'(1);
    deepest = l - LvlW'(1);
    return (l >= LvlW'(1)) && (l <= LvlW'(MaxLevels)) &&
           ((w & mask) == '0) && ((h & mask) == '0) &&
           ((w >> deepest) >= SideW'(8)) && ((h >> deepest) >= SideW'(8)) &&
           (w <= SideW'(MaximumSideSize)) && (h <= SideW'(MaximumSideSize));
  endfunction

  function automatic logic [SideW-1:0] pass_lines(input logic [SideW-1:0] w,
                                                  input logic [SideW-1:0] h,
                                                  input logic [LvlW-1:0]  lvl,
                                                  input pass_dir_t        dir);
    return (dir == DIR_ROW) ? (h >> lvl) : (w >> lvl);
  endfunction

  function automatic logic [SideW-1:0] pass_pairs(input logic [SideW-1:0] w,
                                                  input logic [SideW-1:0] h,
                                                  input logic [LvlW-1:0]  lvl,
                                                  input pass_dir_t        dir);
    return (dir == DIR_ROW) ? ((w >> lvl) >> 1) : ((h >> lvl) >> 1);
  endfunction

  // Zero-latency stream pass-through, gated to FEED.
  assign feed      = (state == S_FEED);
  assign m_valid_o = feed & s_valid_i;
  assign s_ready_o = feed & m_ready_i;
  assign m_data_o  = s_data_i;
  assign m_sof_o   = feed & sof_c;
  assign m_eol_o   = feed & eol_c;
  assign advance   = m_valid_o & m_ready_i;
  assign pass_end  = advance & eol_c & last_line_c;
  assign cmd_fire  = (state == S_ISSUE) & cmd_valid_o & cmd_ready_i;

  // Core output overlaps input, so drain eols count in FEED as well.
  assign drain_inc     = r_valid_i & r_ready_i & r_eol_i &
                         ((state == S_FEED) || (state == S_DRAIN));
  assign drain_cnt_nxt = drain_cnt + SideW'(drain_inc);
  assign lvl_inc       = lvl_q + LvlW'(1);

  dwt97_frame_counter #(
    .SideW(SideW)
  ) u_frame (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clear      (cmd_fire),
    .advance    (advance),
    .pairs      (cmd_pairs_o),
    .lines      (cmd_lines_o),
    .sof_c      (sof_c),
    .eol_c      (eol_c),
    .last_line_c(last_line_c)
  );

  // Sequencer FSM with registered status and descriptor outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      dir_q       <= DIR_ROW;
      w_q         <= '0;
      h_q         <= '0;
      levels_q    <= '0;
      lvl_q       <= '0;
      drain_cnt   <= '0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      error_o     <= 1'b0;
      cmd_valid_o <= 1'b0;
      cmd_dir_o   <= 1'b0;
      cmd_level_o <= '0;
      cmd_lines_o <= '0;
      cmd_pairs_o <= '0;
    end else begin
      done_o    <= 1'b0;
      error_o   <= 1'b0;
      drain_cnt <= drain_cnt_nxt;
      case (state)
        S_IDLE: begin
          busy_o <= start_i;
          if (start_i) begin
            w_q      <= cfg_width_i;
            h_q      <= cfg_height_i;
            levels_q <= cfg_levels_i;
            lvl_q    <= '0;
            dir_q    <= DIR_ROW;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cfg_valid(w_q, h_q, levels_q)) begin
            cmd_valid_o <= 1'b1;
            cmd_dir_o   <= 1'b0;
            cmd_level_o <= '0;
            cmd_lines_o <= pass_lines(w_q, h_q, '0, DIR_ROW);
            cmd_pairs_o <= pass_pairs(w_q, h_q, '0, DIR_ROW);
            state       <= S_ISSUE;
          end else begin
            error_o <= 1'b1;
            state   <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (cmd_fire) begin
            cmd_valid_o <= 1'b0;
            drain_cnt   <= '0;
            state       <= S_FEED;
          end
        end
        S_FEED: begin
          if (pass_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (drain_cnt_nxt == cmd_lines_o) state <= S_NEXT;
        end
        S_NEXT: begin
          if (dir_q == DIR_ROW) begin
            dir_q       <= DIR_COL;
            cmd_valid_o <= 1'b1;
            cmd_dir_o   <= 1'b1;
            cmd_level_o <= lvl_q;
            cmd_lines_o <= pass_lines(w_q, h_q, lvl_q, DIR_COL);
            cmd_pairs_o <= pass_pairs(w_q, h_q, lvl_q, DIR_COL);
            state       <= S_ISSUE;
          end else if (lvl_q == levels_q - LvlW'(1)) begin
            done_o <= 1'b1;
            state  <= S_DONE;
          end else begin
            lvl_q       <= lvl_inc;
            dir_q       <= DIR_ROW;
            cmd_valid_o <= 1'b1;
            cmd_dir_o   <= 1'b0;
            cmd_level_o <= lvl_inc;
            cmd_lines_o <= pass_lines(w_q, h_q, lvl_inc, DIR_ROW);
            cmd_pairs_o <= pass_pairs(w_q, h_q, lvl_inc, DIR_ROW);
            state       <= S_ISSUE;
          end
        end
        S_DONE: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
